// File: rtl/line_fill_ctrl.sv
// Line-fill engine: on a cache miss, reads one aligned line as NW sequential
// 32-bit words, assembles it, and strobes m_done if the cache still wants it.
module line_fill_ctrl #(
  parameter int LW = 512,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m_start,
  input  logic [31:0]   m_addr,
  output logic [LW-1:0] m_data,
  output logic          m_done,
  output logic          mem_rd,
  output logic [31:0]   mem_addr,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ready,
  output logic [CW-1:0] fill_cnt,
  output logic [CW-1:0] disc_cnt
);

  localparam int NW  = LW / 32;
  localparam int OFW = $clog2(LW / 8);
  localparam int BW  = $clog2(NW);
  localparam logic [BW-1:0] LAST_BEAT = BW'(NW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [31-OFW:0] tag_q, tag_d;
  logic [LW-1:0]   data_q, data_d;
  logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]   disc_cnt_q, disc_cnt_d;
  logic            qualified;
  logic            unused_addr_lo;

  assign unused_addr_lo = ^m_addr[OFW-1:0];

  // A finished line is only delivered if the cache is still asking for that same line.
  assign qualified = m_start && (m_addr[31:OFW] == tag_q);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    tag_d      = tag_q;
    data_d     = data_q;
    fill_cnt_d = fill_cnt_q;
    disc_cnt_d = disc_cnt_q;
    m_done     = 1'b0;
    mem_rd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_start) begin
          tag_d   = m_addr[31:OFW];
          beat_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          data_d[32*beat_q +: 32] = mem_rdata;
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (qualified) begin
          m_done     = 1'b1;
          fill_cnt_d = fill_cnt_q + 1'b1;
        end else begin
          disc_cnt_d = disc_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      fill_cnt_q <= '0;
      disc_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      fill_cnt_q <= fill_cnt_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

  // Line offset bits of the word address are exactly the beat index and the byte lane.
  assign mem_addr = {tag_q, beat_q, 2'b00};
  assign m_data   = data_q;
  assign fill_cnt = fill_cnt_q;
  assign disc_cnt = disc_cnt_q;

endmodule
